stack_unit: RTL and testbench

- Hardware operand stack for the multicycle stack CPU; the responder to the controller's `push`/`pop`/`tos` commands.
- The datapath feeds `din` from the memory-to-stack mux or the ALU result.
- `dout` is captured into the A/B operand registers or written back to memory in the cycle after a `pop`/`tos`.
- Single-port storage array plus stack pointer, registered read data, full/empty status and sticky error flags.

---
 rtl/stack_unit.sv | 103 ++++++++++
 tb/tb_stack_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: single-port array,
// count-as-pointer, registered read data and sticky error flags.
module stack_unit #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          tos,
  input  logic [DW-1:0] din,
  input  logic          err_clr,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ovf,
  output logic          udf
);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [DW-1:0] top;

  logic do_push;
  logic do_pop;
  logic do_tos;
  logic do_rep;
  logic ovf_set;
  logic udf_set;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // count[AW-1:0] is 0 when full, so minus one still lands on DEPTH-1
  assign top_idx = count[AW-1:0] - AW'(1);
  assign top     = mem[top_idx];

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_tos  = 1'b0;
    do_rep  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    priority case (1'b1)
      push && pop: begin
        if (empty) begin
          do_push = 1'b1;
          udf_set = 1'b1;
        end else begin
          do_rep = 1'b1;
        end
      end
      push: begin
        if (full) ovf_set = 1'b1;
        else      do_push = 1'b1;
      end
      pop: begin
        if (empty) udf_set = 1'b1;
        else       do_pop  = 1'b1;
      end
      tos: begin
        if (empty) udf_set = 1'b1;
        else       do_tos  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      dout  <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (do_push)
        count <= count + (AW+1)'(1);
      else if (do_pop)
        count <= count - (AW+1)'(1);
      if (do_pop || do_tos || do_rep)
        dout <= top;
      // a coincident error wins over err_clr
      if (ovf_set)      ovf <= 1'b1;
      else if (err_clr) ovf <= 1'b0;
      if (udf_set)      udf <= 1'b1;
      else if (err_clr) udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_push)
        mem[count[AW-1:0]] <= din;
      else if (do_rep)
        mem[top_idx] <= din;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: directed plan then random traffic,
// both checked against a queue-based model.
module tb_stack_unit;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          tos = 1'b0;
  logic [DW-1:0] din = '0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  stack_unit #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos),
    .din(din), .err_clr(err_clr), .dout(dout), .count(count),
    .empty(empty), .full(full), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".count"}, int'(count), q.size());
    chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ".full"},  int'(full),  int'(q.size() == DEPTH));
    chk({tag, ".dout"},  int'(dout),  int'(m_dout));
    chk({tag, ".ovf"},   int'(ovf),   int'(m_ovf));
    chk({tag, ".udf"},   int'(udf),   int'(m_udf));
  endtask

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_step(input logic p, input logic po,
                            input logic t, input logic [DW-1:0] d,
                            input logic c);
    if (c) begin
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    if (p && po) begin
      if (q.size() > 0) begin
        m_dout = q[$];
        q[$] = d;
      end else begin
        q.push_back(d);
        m_udf = 1'b1;
      end
    end else if (p) begin
      if (q.size() == DEPTH) m_ovf = 1'b1;
      else                   q.push_back(d);
    end else if (po) begin
      if (q.size() > 0) m_dout = q.pop_back();
      else              m_udf = 1'b1;
    end else if (t) begin
      if (q.size() > 0) m_dout = q[$];
      else              m_udf = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic p, input logic po,
                      input logic t, input logic [DW-1:0] d,
                      input logic c);
    push = p; pop = po; tos = t; din = d; err_clr = c;
    @(posedge clk);
    model_step(p, po, t, d, c);
    #1;
    push = 0; pop = 0; tos = 0; err_clr = 0;
    chk_all(tag);
  endtask

  initial begin
    model_reset();
    #12;
    chk_all("reset");
    chk("reset.empty_const", int'(empty), 1);
    @(negedge clk);
    rst = 1'b0;

    step("push11", 1, 0, 0, 8'h11, 0);
    step("push22", 1, 0, 0, 8'h22, 0);
    step("push33", 1, 0, 0, 8'h33, 0);
    chk("push3.count_const", int'(count), 3);
    chk("push3.dout_const", int'(dout), 8'h00);
    step("pop33", 0, 1, 0, 8'h00, 0);
    chk("pop33.dout_const", int'(dout), 8'h33);
    step("tos22", 0, 0, 1, 8'h00, 0);
    chk("tos22.dout_const", int'(dout), 8'h22);
    step("pop22", 0, 1, 0, 8'h00, 0);
    step("pop11", 0, 1, 0, 8'h00, 0);
    chk("pop11.dout_const", int'(dout), 8'h11);

    step("pop_empty", 0, 1, 0, 8'h00, 0);
    chk("pop_empty.udf_const", int'(udf), 1);
    step("clr", 0, 0, 0, 8'h00, 1);
    step("pop_empty_clr", 0, 1, 0, 8'h00, 1);
    chk("pop_empty_clr.udf_const", int'(udf), 1);
    step("tos_empty_clr", 0, 0, 1, 8'h00, 1);
    step("clr2", 0, 0, 0, 8'h00, 1);

    for (int i = 0; i < DEPTH; i++)
      step("fill", 1, 0, 0, DW'(i), 0);
    chk("fill.full_const", int'(full), 1);
    step("push_full", 1, 0, 0, 8'hAA, 0);
    chk("push_full.ovf_const", int'(ovf), 1);
    step("tos_full_ign", 1, 0, 1, 8'hBB, 0);
    step("pop_after_ovf", 0, 1, 0, 8'h00, 0);
    chk("pop_after_ovf.dout_const", int'(dout), 8'h0F);
    step("refill", 1, 0, 0, 8'h3C, 0);
    step("rep_full", 1, 1, 0, 8'h5A, 0);
    chk("rep_full.dout_const", int'(dout), 8'h3C);
    while (q.size() > 0)
      step("drain", 0, 1, 0, 8'h00, 0);
    step("clr3", 0, 0, 0, 8'h00, 1);

    step("push05", 1, 0, 0, 8'h05, 0);
    step("push07", 1, 0, 0, 8'h07, 0);
    step("replace", 1, 1, 0, 8'h09, 0);
    chk("replace.dout_const", int'(dout), 8'h07);
    step("tos09", 0, 0, 1, 8'h00, 0);
    chk("tos09.dout_const", int'(dout), 8'h09);
    step("pop_tos_ign", 0, 1, 1, 8'h00, 0);
    step("pop05", 0, 1, 0, 8'h00, 0);
    step("pushpop_empty", 1, 1, 0, 8'h44, 0);

    push = 1; din = 8'hEE;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all("async_rst");
    chk("async_rst.count_const", int'(count), 0);
    #1;
    rst = 1'b0;
    push = 0;
    @(negedge clk);
    chk_all("after_rst");

    for (int i = 0; i < 400; i++) begin
      int r;
      logic p, po, t, c;
      r  = int'($urandom_range(0, 99));
      p  = (r < 45);
      po = (r >= 30 && r < 75);
      t  = ($urandom_range(0, 3) == 0);
      c  = ($urandom_range(0, 9) == 0);
      step("rand", p, po, t, DW'($urandom), c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
